factorial_seq: RTL and testbench



---
 rtl/factorial_seq.sv | 118 +++++++++++
 tb/tb_factorial_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/factorial_seq.sv
// Sequential n! engine: one RW x (OPW+1) multiply per cycle over indices 2..n,
// with a held result, a one-cycle done pulse and a sticky per-operation overflow flag.
module factorial_seq #(
    parameter int OPW = 4,
    parameter int RW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [OPW-1:0] operand,
    output logic           busy,
    output logic           done,
    output logic [RW-1:0]  result,
    output logic           overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [OPW-1:0]    n;
    logic [OPW:0]      idx;
    logic [RW-1:0]     acc;
    logic              ovf_acc;

    logic [RW+OPW:0]   product;
    logic              product_ovf;
    logic              skip_mul;
    logic              last_step;
    logic [RW-1:0]     acc_next;
    logic              ovf_next;

    // Single shared multiplier; overflow is judged on the untruncated product.
    always_comb begin
        product     = {{(OPW+1){1'b0}}, acc} * {{RW{1'b0}}, idx};
        product_ovf = |product[RW+OPW:RW];
        skip_mul    = (idx > {1'b0, n});
        last_step   = skip_mul || (idx == {1'b0, n});
        acc_next    = skip_mul ? acc : product[RW-1:0];
        ovf_next    = skip_mul ? ovf_acc : (ovf_acc | product_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // result/overflow are loaded on the final RUN edge so they are already
    // valid during the DONE cycle, alongside the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            n        <= '0;
            idx      <= '0;
            acc      <= '0;
            ovf_acc  <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n       <= operand;
                        acc     <= {{(RW-1){1'b0}}, (operand != '0)};
                        idx     <= (OPW+1)'(2);
                        ovf_acc <= 1'b0;
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    ovf_acc <= ovf_next;
                    if (last_step) begin
                        result   <= acc_next;
                        overflow <= ovf_next;
                    end else begin
                        idx <= idx + (OPW+1)'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_factorial_seq.sv
// Self-checking bench for factorial_seq: a 32-bit and a 6-bit instance share
// stimulus and are compared against an arithmetic factorial model.
module tb_factorial_seq;

    localparam int OPW = 4;
    localparam int RW  = 32;
    localparam int RWN = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [OPW-1:0] operand;

    logic           busy, done, overflow;
    logic [RW-1:0]  result;
    logic           busy_n, done_n, overflow_n;
    logic [RWN-1:0] result_n;

    int checks = 0;
    int passed = 0;

    factorial_seq #(.OPW(OPW), .RW(RW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .operand  (operand),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    factorial_seq #(.OPW(OPW), .RW(RWN)) dut_narrow (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .operand  (operand),
        .busy     (busy_n),
        .done     (done_n),
        .result   (result_n),
        .overflow (overflow_n)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned fact(input int n);
        longint unsigned f = 1;
        for (int i = 2; i <= n; i++) f = f * longint'(i);
        return f;
    endfunction

    // Operand 0 is defined to produce 0, not 1.
    function automatic longint unsigned ref_result(input int n, input int rw);
        if (n == 0) return 0;
        return fact(n) & ((64'd1 << rw) - 64'd1);
    endfunction

    function automatic logic ref_ovf(input int n, input int rw);
        if (n == 0) return 1'b0;
        return (fact(n) >> rw) != 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input int n);
        logic [RW-1:0]  exp_r;
        logic [RWN-1:0] exp_rn;
        logic           exp_o, exp_on;
        exp_r  = RW'(ref_result(n, RW));
        exp_rn = RWN'(ref_result(n, RWN));
        exp_o  = ref_ovf(n, RW);
        exp_on = ref_ovf(n, RWN);
        checks++;
        if (result !== exp_r) $display("[TB] FAIL %s result n=%0d: got %0d, expected %0d", tag, n, result, exp_r);
        else passed++;
        checks++;
        if (overflow !== exp_o) $display("[TB] FAIL %s overflow n=%0d: got %b, expected %b", tag, n, overflow, exp_o);
        else passed++;
        checks++;
        if (result_n !== exp_rn) $display("[TB] FAIL %s narrow result n=%0d: got %0d, expected %0d", tag, n, result_n, exp_rn);
        else passed++;
        checks++;
        if (overflow_n !== exp_on) $display("[TB] FAIL %s narrow overflow n=%0d: got %b, expected %b", tag, n, overflow_n, exp_on);
        else passed++;
    endtask

    // Starts one operation from IDLE and checks busy/done timing cycle by cycle.
    task automatic run_op(input int n, input string tag);
        int lat;
        lat     = (n <= 1) ? 1 : n - 1;
        start   = 1'b1;
        operand = OPW'(n);
        step();
        start   = 1'b0;
        operand = OPW'($urandom_range(0, 15));
        for (int c = 1; c <= lat + 1; c++) begin
            checks++;
            if (busy !== 1'b1) $display("[TB] FAIL %s busy at T+%0d: got %b, expected 1", tag, c, busy);
            else passed++;
            checks++;
            if (done !== (c == lat + 1)) $display("[TB] FAIL %s done at T+%0d: got %b, expected %b", tag, c, done, (c == lat + 1));
            else passed++;
            if (c < lat + 1) step();
        end
        check_outputs(tag, n);
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL %s idle after done: got busy=%b done=%b, expected 0 0", tag, busy, done);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; operand = 4'd5;
        step(); step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL reset busy/done: got %b %b, expected 0 0", busy, done);
        else passed++;
        checks++;
        if (result !== '0 || overflow !== 1'b0) $display("[TB] FAIL reset result/overflow: got %0d %b, expected 0 0", result, overflow);
        else passed++;
        rst = 1'b0; start = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL reset start ignored: got busy=%b, expected 0", busy);
        else passed++;
    endtask

    task automatic test_directed();
        run_op(3, "n3");
        run_op(0, "n0");
        run_op(1, "n1");
        run_op(12, "n12");
        run_op(13, "n13");
        run_op(4, "n4");
        run_op(5, "n5");
        run_op(15, "n15");
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            run_op(int'($urandom_range(0, 15)), "rand");
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic test_result_hold();
        run_op(6, "hold_setup");
        for (int k = 0; k < 4; k++) begin
            operand = OPW'($urandom_range(0, 15));
            step();
            check_outputs("hold", 6);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; operand = 4'd5;
        step();
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) operand = 4'd2;
            checks++;
            if (busy !== 1'b1 || done !== (c == 5))
                $display("[TB] FAIL b2b first T+%0d: got busy=%b done=%b, expected 1 %b", c, busy, done, (c == 5));
            else passed++;
            if (c < 5) step();
        end
        check_outputs("b2b_first", 5);
        step();
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL b2b idle at T+6: got busy=%b, expected 0", busy);
        else passed++;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) $display("[TB] FAIL b2b accept at T+6: got busy=%b done=%b, expected 1 0", busy, done);
        else passed++;
        step();
        checks++;
        if (done !== 1'b1) $display("[TB] FAIL b2b second done: got %b, expected 1", done);
        else passed++;
        check_outputs("b2b_second", 2);
        step();
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; operand = 4'd7;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL midrst busy/done: got %b %b, expected 0 0", busy, done);
        else passed++;
        checks++;
        if (result !== '0 || overflow !== 1'b0 || result_n !== '0 || overflow_n !== 1'b0)
            $display("[TB] FAIL midrst cleared: got %0d %b %0d %b, expected 0 0 0 0", result, overflow, result_n, overflow_n);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL midrst stray activity: got busy=%b done=%b, expected 0 0", busy, done);
            else passed++;
        end
        run_op(7, "after_rst");
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; operand = '0;
        test_reset();
        test_directed();
        test_random();
        test_result_hold();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    always @(negedge clk) begin
        if (done && !busy) $display("[TB] FAIL done without busy: got done=1 busy=0, expected busy=1");
    end

endmodule
